// File: rtl/tx_vc_router.sv
// Link-layer transmit router: main FIFO -> per-VC FIFOs -> round-robin arbiter
// -> one registered valid/ready output register per destination.
module tx_vc_router #(
  parameter int DATA_W     = 6,
  parameter int VC_W       = 1,
  parameter int DEST_W     = 1,
  parameter int MAIN_DEPTH = 4,
  parameter int VC_DEPTH   = 16,
  parameter int MAIN_HIGH  = 3,
  localparam int NUM_VC    = 2**VC_W,
  localparam int NUM_DEST  = 2**DEST_W
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic [DATA_W-1:0]            DATA_IN_TX,
  input  logic                         PUSH,
  output logic                         PAUSE_MAIN,
  output logic                         MAIN_ERR,
  output logic [NUM_DEST*DATA_W-1:0]   DATA_OUT,
  output logic [NUM_DEST-1:0]          VALID_OUT,
  input  logic [NUM_DEST-1:0]          READY_IN,
  output logic                         IDLE
);

  localparam int MAIN_AW  = $clog2(MAIN_DEPTH);
  localparam int VC_AW    = $clog2(VC_DEPTH);
  localparam int DEST_LSB = DATA_W - VC_W - DEST_W;

  typedef logic [DATA_W-1:0] word_t;

  // Main FIFO
  word_t               main_mem [MAIN_DEPTH];
  logic [MAIN_AW-1:0]  main_wr_q, main_wr_d, main_rd_q, main_rd_d;
  logic [MAIN_AW:0]    main_cnt_q, main_cnt_d;
  logic                main_empty, main_full, main_push, main_pop;
  word_t               head_word;
  logic [VC_W-1:0]     head_vc;

  // VC FIFOs
  word_t               vc_mem [NUM_VC][VC_DEPTH];
  logic [VC_AW-1:0]    vc_wr_q [NUM_VC], vc_wr_d [NUM_VC];
  logic [VC_AW-1:0]    vc_rd_q [NUM_VC], vc_rd_d [NUM_VC];
  logic [VC_AW:0]      vc_cnt_q [NUM_VC], vc_cnt_d [NUM_VC];
  word_t               vc_head [NUM_VC];
  logic [NUM_VC-1:0]   vc_empty, vc_full, vc_push, vc_pop;

  // Arbiter and output registers
  logic [NUM_DEST-1:0] out_free;
  logic [VC_W-1:0]     cand;
  logic                grant_vld;
  logic [VC_W-1:0]     grant_vc;
  word_t               grant_word;
  logic [DEST_W-1:0]   grant_dest;
  logic [VC_W-1:0]     rr_q, rr_d;
  logic [NUM_DEST-1:0] valid_q, valid_d;
  word_t               data_q [NUM_DEST], data_d [NUM_DEST];
  logic                pause_q, pause_d, err_q, err_d;

  always_comb begin
    main_empty = (main_cnt_q == '0);
    main_full  = (main_cnt_q == (MAIN_AW+1)'(MAIN_DEPTH));
    head_word  = main_mem[main_rd_q];
    head_vc    = head_word[DATA_W-1 -: VC_W];
    for (int v = 0; v < NUM_VC; v++) begin
      vc_head[v]  = vc_mem[v][vc_rd_q[v]];
      vc_empty[v] = (vc_cnt_q[v] == '0);
      vc_full[v]  = (vc_cnt_q[v] == (VC_AW+1)'(VC_DEPTH));
    end
    // A full main FIFO still accepts a push when the head leaves in the same cycle.
    main_pop  = !main_empty && !vc_full[head_vc];
    main_push = PUSH && (!main_full || main_pop);
  end

  // Round-robin search starting at rr_q; first eligible VC wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    out_free  = ~valid_q | READY_IN;
    grant_vld = 1'b0;
    grant_vc  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      cand = rr_q + VC_W'(i);
      if (!grant_vld && !vc_empty[cand] &&
          out_free[vc_head[cand][DEST_LSB +: DEST_W]]) begin
        grant_vld = 1'b1;
        grant_vc  = cand;
      end
    end
    grant_word = vc_head[grant_vc];
    grant_dest = grant_word[DEST_LSB +: DEST_W];
  end

  always_comb begin
    main_wr_d  = main_wr_q;
    main_rd_d  = main_rd_q;
    main_cnt_d = main_cnt_q;
    if (main_push) main_wr_d = main_wr_q + MAIN_AW'(1);
    if (main_pop)  main_rd_d = main_rd_q + MAIN_AW'(1);
    case ({main_push, main_pop})
      2'b10:   main_cnt_d = main_cnt_q + (MAIN_AW+1)'(1);
      2'b01:   main_cnt_d = main_cnt_q - (MAIN_AW+1)'(1);
      default: main_cnt_d = main_cnt_q;
    endcase
    err_d   = err_q | (PUSH & ~main_push);
    pause_d = (main_cnt_d >= (MAIN_AW+1)'(MAIN_HIGH));
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      vc_push[v]  = main_pop && (head_vc == VC_W'(v));
      vc_pop[v]   = grant_vld && (grant_vc == VC_W'(v));
      vc_wr_d[v]  = vc_wr_q[v];
      vc_rd_d[v]  = vc_rd_q[v];
      vc_cnt_d[v] = vc_cnt_q[v];
      if (vc_push[v]) vc_wr_d[v] = vc_wr_q[v] + VC_AW'(1);
      if (vc_pop[v])  vc_rd_d[v] = vc_rd_q[v] + VC_AW'(1);
      if (vc_push[v] && !vc_pop[v]) vc_cnt_d[v] = vc_cnt_q[v] + (VC_AW+1)'(1);
      if (!vc_push[v] && vc_pop[v]) vc_cnt_d[v] = vc_cnt_q[v] - (VC_AW+1)'(1);
    end
  end

  // An accepted output clears; a grant to the same destination reloads it.
  always_comb begin
    valid_d = valid_q & ~READY_IN;
    rr_d    = rr_q;
    for (int d = 0; d < NUM_DEST; d++) data_d[d] = data_q[d];
    if (grant_vld) begin
      valid_d[grant_dest] = 1'b1;
      data_d[grant_dest]  = grant_word;
      rr_d                = grant_vc + VC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      main_wr_q  <= '0;
      main_rd_q  <= '0;
      main_cnt_q <= '0;
      rr_q       <= '0;
      valid_q    <= '0;
      pause_q    <= 1'b0;
      err_q      <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        vc_wr_q[v]  <= '0;
        vc_rd_q[v]  <= '0;
        vc_cnt_q[v] <= '0;
      end
      for (int d = 0; d < NUM_DEST; d++) data_q[d] <= '0;
    end else begin
      main_wr_q  <= main_wr_d;
      main_rd_q  <= main_rd_d;
      main_cnt_q <= main_cnt_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      pause_q    <= pause_d;
      err_q      <= err_d;
      for (int v = 0; v < NUM_VC; v++) begin
        vc_wr_q[v]  <= vc_wr_d[v];
        vc_rd_q[v]  <= vc_rd_d[v];
        vc_cnt_q[v] <= vc_cnt_d[v];
      end
      for (int d = 0; d < NUM_DEST; d++) data_q[d] <= data_d[d];
    end
  end

  // NOTE: storage arrays are deliberately not reset; pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (main_push) main_mem[main_wr_q] <= DATA_IN_TX;
    if (main_pop)  vc_mem[head_vc][vc_wr_q[head_vc]] <= head_word;
  end

  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) DATA_OUT[d*DATA_W +: DATA_W] = data_q[d];
  end

  assign VALID_OUT  = valid_q;
  assign PAUSE_MAIN = pause_q;
  assign MAIN_ERR   = err_q;
  assign IDLE       = main_empty && (&vc_empty) && (valid_q == '0);

endmodule
